// File: rtl/sr_latch_seq_ctrl.sv
// sr_latch_seq_ctrl: arbitrated pulse sequencer for an active-low NAND SR latch with feedback checking
module sr_latch_seq_ctrl #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic force_pre,
  input  logic force_clr,
  input  logic err_clr,
  input  logic q_fb,
  input  logic qb_fb,
  output logic s_n,
  output logic r_n,
  output logic pre_n,
  output logic clr_n,
  output logic set_ack,
  output logic clr_ack,
  output logic force_ack,
  output logic busy,
  output logic q_exp,
  output logic err
);
  localparam int MX = PULSE_W > GAP_W ? PULSE_W : GAP_W;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  typedef enum logic [1:0] {OP_SET, OP_CLR, OP_PRE, OP_FCL} op_t;
  state_t state_q, state_d;
  op_t op_q, op_d, lo_op;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rr_q, rr_d;
  logic s_n_q, s_n_d, r_n_q, r_n_d, pre_n_q, pre_n_d, clr_n_q, clr_n_d;
  logic set_ack_q, set_ack_d, clr_ack_q, clr_ack_d, force_ack_q, force_ack_d;
  logic busy_q, busy_d, q_exp_q, q_exp_d, err_q, err_d;
  logic q_s1_q, q_s2_q, qb_s1_q, qb_s2_q;
  logic lo, mism;
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    q_exp_d     = q_exp_q;
    lo          = 1'b0;
    lo_op       = op_q;
    set_ack_d   = 1'b0;
    clr_ack_d   = 1'b0;
    force_ack_d = 1'b0;
    mism        = 1'b0;
    case (state_q)
      IDLE: if (force_pre || force_clr || set_req || clr_req) begin
        // rr_q high means set was served last, so a tie goes to clr
        op_d    = force_pre ? OP_PRE : force_clr ? OP_FCL :
                  (set_req && !(clr_req && rr_q)) ? OP_SET : OP_CLR;
        state_d = PULSE;
        cnt_d   = CW'(PULSE_W);
        lo      = 1'b1;
        lo_op   = op_d;
      end
      PULSE: if (cnt_q == CW'(1)) begin
        state_d = GAP;
        cnt_d   = CW'(GAP_W);
        q_exp_d = (op_q == OP_SET) || (op_q == OP_PRE);
      end else begin
        cnt_d = cnt_q - 1'b1;
        lo    = 1'b1;
      end
      GAP: begin
        cnt_d = cnt_q - 1'b1;
        // decided one cycle early so ack and err are visible in the last gap cycle
        if (cnt_q == CW'(2)) begin
          set_ack_d   = op_q == OP_SET;
          clr_ack_d   = op_q == OP_CLR;
          force_ack_d = (op_q == OP_PRE) || (op_q == OP_FCL);
          mism        = (q_s2_q != q_exp_q) || (qb_s2_q == q_exp_q);
        end
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          rr_d    = (op_q == OP_SET || op_q == OP_CLR) ? (op_q == OP_SET) : rr_q;
        end
      end
      default: state_d = IDLE;
    endcase
    s_n_d   = !(lo && lo_op == OP_SET);
    r_n_d   = !(lo && lo_op == OP_CLR);
    pre_n_d = !(lo && lo_op == OP_PRE);
    clr_n_d = !(lo && lo_op == OP_FCL);
    busy_d  = state_d != IDLE;
    err_d   = mism || (err_q && !err_clr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_SET;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      s_n_q       <= 1'b1;
      r_n_q       <= 1'b1;
      pre_n_q     <= 1'b1;
      clr_n_q     <= 1'b1;
      set_ack_q   <= 1'b0;
      clr_ack_q   <= 1'b0;
      force_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      q_exp_q     <= 1'b0;
      err_q       <= 1'b0;
      q_s1_q      <= 1'b0;
      q_s2_q      <= 1'b0;
      qb_s1_q     <= 1'b0;
      qb_s2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      s_n_q       <= s_n_d;
      r_n_q       <= r_n_d;
      pre_n_q     <= pre_n_d;
      clr_n_q     <= clr_n_d;
      set_ack_q   <= set_ack_d;
      clr_ack_q   <= clr_ack_d;
      force_ack_q <= force_ack_d;
      busy_q      <= busy_d;
      q_exp_q     <= q_exp_d;
      err_q       <= err_d;
      q_s1_q      <= q_fb;
      q_s2_q      <= q_s1_q;
      qb_s1_q     <= qb_fb;
      qb_s2_q     <= qb_s1_q;
    end
  end
  assign s_n       = s_n_q;
  assign r_n       = r_n_q;
  assign pre_n     = pre_n_q;
  assign clr_n     = clr_n_q;
  assign set_ack   = set_ack_q;
  assign clr_ack   = clr_ack_q;
  assign force_ack = force_ack_q;
  assign busy      = busy_q;
  assign q_exp     = q_exp_q;
  assign err       = err_q;
endmodule
